vga_fb_scanout: RTL and testbench
=================================

Name: vga_fb_scanout

Overview:
- Sits directly downstream of the VGA timing generator; consumes its x/y/valid/hsync/vsync/newline/newframe outputs.
- Fetches 4-bit colour indices from an external low-resolution framebuffer RAM (160x120, each framebuffer pixel drawn as 4x4 screen pixels).
- Maps each index through a 16-entry palette and drives 12-bit RGB with syncs delayed to match.
- Palette writes from game logic go to a shadow copy, which is committed to the active palette only at frame start, so there is no mid-frame tearing.

Parameters:
- FB_W, 160, framebuffer width in framebuffer pixels.
- FB_H, 120, framebuffer height in framebuffer pixels.
- SCALE_SH, 2, log2 of screen pixels per framebuffer pixel per axis.
- RAM_LAT, 2, read latency of the framebuffer RAM in clk cycles (1..4).
- IDX_W, 4, colour index width (palette depth 2^IDX_W).

Ports:
- clk  in  1  system clock (same clock as timing generator)
- rst_n  in  1  asynchronous active-low reset
- x  in  10  current column from timing generator
- y  in  10  current row from timing generator
- valid  in  1  active-video flag from timing generator
- hsync  in  1  active-low hsync from timing generator
- vsync  in  1  active-low vsync from timing generator
- newframe  in  1  one-cycle pulse at frame start
- ram_addr  out  15  framebuffer read address
- ram_rdata  in  IDX_W  colour index, valid RAM_LAT cycles after ram_addr
- pal_wr_valid  in  1  palette write request
- pal_wr_ready  out  1  palette write accept
- pal_wr_idx  in  IDX_W  palette entry to write
- pal_wr_rgb  in  12  {R[3:0],G[3:0],B[3:0]} for entry
- rgb  out  12  pixel colour to DAC pins
- hsync_o  out  1  hsync aligned to rgb
- vsync_o  out  1  vsync aligned to rgb
- vblank  out  1  high while the aligned row is >= 480
- frame_cnt  out  16  frames started since reset

Behaviour:
- Clock/reset: single clk domain. rst_n is asynchronous assert and synchronous deassert (two-flop synchroniser inside).
- Reset values:
  - rgb=0, hsync_o=1, vsync_o=1, vblank=0, frame_cnt=0, ram_addr=0, pal_wr_ready=0.
  - All pipeline valid bits 0; dirty flag 0.
  - Active and shadow palette entry i = {i,i,i} (grey ramp).
- Address stage (cycle 0 -> 1), registered: ram_addr = (y>>SCALE_SH)*FB_W + (x>>SCALE_SH). The multiply by 160 is implemented as shift-add (<<7 plus <<5). When valid=0, ram_addr holds its last value.
- Pipeline:
  - Total latency L = RAM_LAT+2 clk from x/y/syncs input to rgb/hsync_o/vsync_o: address reg, RAM_LAT RAM cycles, palette/output reg.
  - valid, hsync, vsync and (y>=480) travel through an L-deep delay line.
  - Every stage advances every clk; upstream holds each x for 2 clk, which the pipeline ignores.
- Output stage: rgb = active_pal[ram_rdata] if the delayed valid is 1, else 12'h000. Blanking is forced black regardless of RAM data.
- Palette write handshake:
  - Transfer occurs when pal_wr_valid && pal_wr_ready. On transfer, shadow[pal_wr_idx] <= pal_wr_rgb and dirty <= 1.
  - pal_wr_ready = 1 except in reset and in the commit cycle.
  - Requester holds idx/rgb stable while valid && !ready.
- Commit:
  - On a cycle with newframe=1 && dirty=1: active <= shadow (all entries), dirty <= 0, pal_wr_ready=0 that cycle.
  - A write stalled by the commit is accepted the next cycle and sets dirty again; it becomes visible at the following frame.
  - newframe with dirty=0 leaves active unchanged and ready stays 1.
- frame_cnt: increments by 1 on every newframe pulse and wraps 0xFFFF -> 0x0000. The pulse upstream emits during its own reset counts.
- Reset mid-frame: pipeline flushed to blank. Palettes return to the grey ramp, pending writes are lost, and dirty is cleared.
- Out-of-range: x>=640 or y>=480 produce no visible pixel (valid=0). Addresses computed there are don't-care, but never exceed 32767.

Decomposition:
- Shared package vga_pkg holds:
  - H_ACTIVE=640, V_ACTIVE=480, RGB_W=12.
  - The rgb12 typedef {r,g,b} 4 bits each.
  - The default_pal(i) function.
- Sub-module vga_delay_line (parameters WIDTH, DEPTH) carries {valid, hsync, vsync, vblank}. Register-only, reset to {0,1,1,0}.

Test Plan:
1. Reset + idle: hold rst_n=0, then release -> rgb=000, hsync_o=vsync_o=1, frame_cnt=0. pal_wr_ready rises within 3 clk after release.
2. Address/latency: RAM model returns addr[3:0]. Drive x=12, y=9 with valid=1 -> ram_addr=2*160+3=323 one clk later. rgb=333 (grey ramp) exactly RAM_LAT+2 clk after input.
3. Blanking/sync alignment: run a full 800x525 frame. hsync_o low for exactly 192 clk per line (96 pixels x 2), starting L clk after upstream hsync falls. rgb=000 whenever delayed valid=0. vblank high for 45 lines.
4. Deferred palette: mid-frame write idx=5 rgb=F00 -> accepted, but pixels with index 5 stay 555 for the rest of the frame. After the next newframe they show F00.
5. Write/commit collision: assert pal_wr_valid (idx=2, rgb=0F0) with dirty=1 in the newframe cycle -> ready=0, transfer on the next clk. Index 2 shows 0F0 only from the frame after next.
6. Counter wrap + async reset: preload via 65536 newframe pulses -> frame_cnt wraps to 0. Assert rst_n low mid-line -> outputs go to reset values without a clk edge.

Source files
------------

// File: rtl/vga_pkg.sv
// vga_pkg: shared VGA geometry, the 12-bit colour type and the power-up grey-ramp palette
package vga_pkg;
    localparam int H_ACTIVE = 640;
    localparam int V_ACTIVE = 480;
    localparam int RGB_W    = 12;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb12;

    function automatic rgb12 default_pal(input logic [3:0] i);
        return '{r: i, g: i, b: i};
    endfunction
endpackage

// File: rtl/vga_delay_line.sv
// vga_delay_line: fixed-depth register pipeline that keeps control bits aligned with the pixel path
module vga_delay_line #(
    parameter int               WIDTH   = 4,
    parameter int               DEPTH   = 3,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    logic [WIDTH-1:0] pipe_q [DEPTH];
    logic [WIDTH-1:0] pipe_d [DEPTH];

    // Each stage takes the previous one; stage 0 takes the input
    always_comb begin
        pipe_d[0] = d;
        for (int i = 1; i < DEPTH; i++) pipe_d[i] = pipe_q[i-1];
    end

    // Shift every clock; reset flushes to the idle pattern
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) pipe_q[i] <= RST_VAL;
        end else begin
            pipe_q <= pipe_d;
        end

    assign q = pipe_q[DEPTH-1];
endmodule

// File: rtl/vga_fb_scanout.sv
// vga_fb_scanout: fetches framebuffer indices, maps them through a frame-synchronous palette, drives RGB with aligned syncs
module vga_fb_scanout
    import vga_pkg::*;
#(
    parameter int FB_W     = 160,
    parameter int FB_H     = 120,
    parameter int SCALE_SH = 2,
    parameter int RAM_LAT  = 2,
    parameter int IDX_W    = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [9:0]       x,
    input  logic [9:0]       y,
    input  logic             valid,
    input  logic             hsync,
    input  logic             vsync,
    input  logic             newframe,
    output logic [14:0]      ram_addr,
    input  logic [IDX_W-1:0] ram_rdata,
    input  logic             pal_wr_valid,
    output logic             pal_wr_ready,
    input  logic [IDX_W-1:0] pal_wr_idx,
    input  logic [RGB_W-1:0] pal_wr_rgb,
    output logic [RGB_W-1:0] rgb,
    output logic             hsync_o,
    output logic             vsync_o,
    output logic             vblank,
    output logic [15:0]      frame_cnt
);
    localparam int PAL_N = 1 << IDX_W;

    logic [1:0]  rst_sync_q, rst_sync_d;
    logic        rst_int_n;
    logic        vis, commit, wr_fire;
    logic [14:0] row, col, ram_addr_q, ram_addr_d;
    logic [3:0]  dl_q;
    rgb12        rgb_q, rgb_d;
    logic        hsync_q, hsync_d, vsync_q, vsync_d, vblank_q, vblank_d, dirty_q, dirty_d;
    logic [15:0] frame_cnt_q, frame_cnt_d;
    rgb12        active_q [PAL_N];
    rgb12        active_d [PAL_N];
    rgb12        shadow_q [PAL_N];
    rgb12        shadow_d [PAL_N];

    // Reset synchroniser shifts in ones: asserts at once, releases two clocks after rst_n rises
    always_comb rst_sync_d = {rst_sync_q[0], 1'b1};

    // Synchroniser flops, cleared directly by the external reset
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) rst_sync_q <= '0;
        else        rst_sync_q <= rst_sync_d;

    assign rst_int_n = rst_sync_q[1];

    // Address stage: scale to framebuffer coords; row*160 is (row<<7)+(row<<5), so FB_W is fixed at 160
    always_comb begin
        vis        = valid && (x < 10'(FB_W << SCALE_SH)) && (y < 10'(FB_H << SCALE_SH));
        row        = 15'(y >> SCALE_SH);
        col        = 15'(x >> SCALE_SH);
        ram_addr_d = vis ? (row << 7) + (row << 5) + col : ram_addr_q;
    end

    vga_delay_line #(
        .WIDTH  (4),
        .DEPTH  (RAM_LAT + 1),
        .RST_VAL(4'b0110)
    ) u_dly (
        .clk  (clk),
        .rst_n(rst_int_n),
        .d    ({vis, hsync, vsync, y >= 10'(V_ACTIVE)}),
        .q    (dl_q)
    );

    // Output stage: palette lookup, forced black whenever the aligned pixel is not visible
    always_comb begin
        rgb_d    = dl_q[3] ? active_q[ram_rdata] : '0;
        hsync_d  = dl_q[2];
        vsync_d  = dl_q[1];
        vblank_d = dl_q[0];
    end

    // Palette writes land in the shadow copy; a frame start with pending writes copies it to active
    always_comb begin
        commit       = newframe && dirty_q;
        pal_wr_ready = rst_int_n && !commit;
        wr_fire      = pal_wr_valid && pal_wr_ready;
        shadow_d     = shadow_q;
        if (wr_fire) shadow_d[pal_wr_idx] = pal_wr_rgb;
        active_d     = active_q;
        if (commit) active_d = shadow_q;
        dirty_d      = wr_fire || (dirty_q && !commit);
        frame_cnt_d  = frame_cnt_q + 16'(newframe);
    end

    // All pipeline and palette state, reset from the synchronised reset
    always_ff @(posedge clk or negedge rst_int_n)
        if (!rst_int_n) begin
            ram_addr_q  <= '0;
            rgb_q       <= '0;
            hsync_q     <= 1'b1;
            vsync_q     <= 1'b1;
            vblank_q    <= 1'b0;
            dirty_q     <= 1'b0;
            frame_cnt_q <= '0;
            for (int i = 0; i < PAL_N; i++) begin
                active_q[i] <= default_pal(4'(i));
                shadow_q[i] <= default_pal(4'(i));
            end
        end else begin
            ram_addr_q  <= ram_addr_d;
            rgb_q       <= rgb_d;
            hsync_q     <= hsync_d;
            vsync_q     <= vsync_d;
            vblank_q    <= vblank_d;
            dirty_q     <= dirty_d;
            frame_cnt_q <= frame_cnt_d;
            active_q    <= active_d;
            shadow_q    <= shadow_d;
        end

    assign ram_addr  = ram_addr_q;
    assign rgb       = rgb_q;
    assign hsync_o   = hsync_q;
    assign vsync_o   = vsync_q;
    assign vblank    = vblank_q;
    assign frame_cnt = frame_cnt_q;
endmodule

// File: tb/tb_vga_fb_scanout.sv
// tb_vga_fb_scanout: directed scenarios for the framebuffer scanout with a RAM model returning addr[3:0]
module tb_vga_fb_scanout;
    localparam int RAM_LAT = 2;
    localparam int L = RAM_LAT + 2;

    logic        clk = 0, rst_n = 0;
    logic [9:0]  x = 0, y = 0;
    logic        valid = 0, hsync = 1, vsync = 1, newframe = 0;
    logic [14:0] ram_addr;
    logic [3:0]  ram_rdata;
    logic        pal_wr_valid = 0, pal_wr_ready;
    logic [3:0]  pal_wr_idx = 0;
    logic [11:0] pal_wr_rgb = 0, rgb;
    logic        hsync_o, vsync_o, vblank;
    logic [15:0] frame_cnt;
    logic [15:0] exp_fc = 0;
    logic [3:0]  ram_p1, ram_p2;
    int          vectors = 0, errors = 0;

    vga_fb_scanout #(.RAM_LAT(RAM_LAT)) dut (
        .clk(clk), .rst_n(rst_n), .x(x), .y(y), .valid(valid), .hsync(hsync), .vsync(vsync),
        .newframe(newframe), .ram_addr(ram_addr), .ram_rdata(ram_rdata),
        .pal_wr_valid(pal_wr_valid), .pal_wr_ready(pal_wr_ready), .pal_wr_idx(pal_wr_idx),
        .pal_wr_rgb(pal_wr_rgb), .rgb(rgb), .hsync_o(hsync_o), .vsync_o(vsync_o),
        .vblank(vblank), .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        ram_p1 <= ram_addr[3:0];
        ram_p2 <= ram_p1;
    end
    assign ram_rdata = ram_p2;

    task automatic step(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pix(input int px, input int py, output logic [11:0] r);
        x = 10'(px); y = 10'(py); valid = 1;
        step(L);
        r = rgb;
        valid = 0;
    endtask

    task automatic nf();
        newframe = 1;
        step();
        newframe = 0;
        exp_fc++;
    endtask

    task automatic pal_write(input logic [3:0] i, input logic [11:0] c);
        int t = 0;
        pal_wr_valid = 1; pal_wr_idx = i; pal_wr_rgb = c;
        #1;
        while (pal_wr_ready !== 1'b1 && t < 4) begin step(); t++; end
        vectors++;
        if (pal_wr_ready !== 1'b1) begin errors++; $display("FAIL pal_write_wait: ready=%b required 1", pal_wr_ready); end
        step();
        pal_wr_valid = 0;
    endtask

    task automatic test_reset();
        int t = 0;
        rst_n = 0;
        step(3);
        vectors++;
        if ({rgb, hsync_o, vsync_o, vblank} !== {12'h000, 3'b110}) begin
            errors++; $display("FAIL reset_outputs: got rgb=%h hs=%b vs=%b vb=%b required 000 1 1 0", rgb, hsync_o, vsync_o, vblank);
        end
        vectors++;
        if (frame_cnt !== 16'h0 || ram_addr !== 15'h0) begin
            errors++; $display("FAIL reset_cnt_addr: got %h/%h required 0000/0000", frame_cnt, ram_addr);
        end
        vectors++;
        if (pal_wr_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b required 0", pal_wr_ready); end
        rst_n = 1;
        while (pal_wr_ready !== 1'b1 && t < 3) begin step(); t++; end
        vectors++;
        if (pal_wr_ready !== 1'b1) begin errors++; $display("FAIL ready_rise: got %b required 1 within 3 clk", pal_wr_ready); end
        vectors++;
        if (frame_cnt !== 16'h0 || rgb !== 12'h000) begin
            errors++; $display("FAIL post_release: got cnt=%h rgb=%h required 0000 000", frame_cnt, rgb);
        end
    endtask

    task automatic test_latency();
        x = 12; y = 9; valid = 1;
        step();
        vectors++;
        if (ram_addr !== 15'd323) begin errors++; $display("FAIL addr_12_9: got %0d required 323", ram_addr); end
        valid = 0;
        step(L - 2);
        vectors++;
        if (rgb !== 12'h000) begin errors++; $display("FAIL latency_early: got %h required 000", rgb); end
        step();
        vectors++;
        if (rgb !== 12'h333) begin errors++; $display("FAIL latency_exact: got %h required 333", rgb); end
        step();
        vectors++;
        if (rgb !== 12'h000) begin errors++; $display("FAIL blank_after: got %h required 000", rgb); end
        x = 639; y = 479; valid = 1;
        step();
        vectors++;
        if (ram_addr !== 15'd19199) begin errors++; $display("FAIL addr_corner: got %0d required 19199", ram_addr); end
        x = 0; y = 0; valid = 0;
        step(2);
        vectors++;
        if (ram_addr !== 15'd19199) begin errors++; $display("FAIL addr_hold: got %0d required 19199", ram_addr); end
    endtask

    task automatic test_frame();
        logic [11:0] e_rgb [8];
        logic [2:0]  e_ctl [8];
        int rows [4] = '{0, 479, 480, 490};
        int n = 0, bad_rgb = 0, bad_ctl = 0, low, f_in, f_out, vb_cnt = 0, xi, yi;
        for (int li = 0; li < 4; li++) begin
            low = 0; f_in = -1; f_out = -1;
            for (int k = 0; k < 1600; k++) begin
                step();
                if (n >= L) begin
                    if (rgb !== e_rgb[(n - L) % 8]) bad_rgb++;
                    if ({hsync_o, vsync_o, vblank} !== e_ctl[(n - L) % 8]) bad_ctl++;
                end
                if (hsync_o === 1'b0) begin low++; if (f_out < 0) f_out = k; end
                xi = k / 2; yi = rows[li];
                x = 10'(xi); y = 10'(yi);
                valid = xi < 640 && yi < 480;
                hsync = !(xi >= 656 && xi < 752);
                vsync = !(yi == 490 || yi == 491);
                if (!hsync && f_in < 0) f_in = k;
                e_rgb[n % 8] = valid ? {3{4'(xi >> 2)}} : 12'h000;
                e_ctl[n % 8] = {hsync, vsync, yi >= 480};
                n++;
            end
            vectors++;
            if (low !== 192) begin errors++; $display("FAIL hsync_width row %0d: got %0d required 192", yi, low); end
            vectors++;
            if (f_out - f_in !== L) begin errors++; $display("FAIL hsync_delay row %0d: got %0d required %0d", yi, f_out - f_in, L); end
        end
        vectors++;
        if (bad_rgb !== 0) begin errors++; $display("FAIL frame_rgb: got %0d wrong pixels required 0", bad_rgb); end
        vectors++;
        if (bad_ctl !== 0) begin errors++; $display("FAIL frame_sync: got %0d wrong cycles required 0", bad_ctl); end
        x = 700; y = 0; valid = 0; hsync = 1; vsync = 1;
        step(L);
        for (int k = 0; k < 525 + L; k++) begin
            y = (k < 525) ? 10'(k) : 10'd0;
            step();
            if (vblank === 1'b1) vb_cnt++;
        end
        vectors++;
        if (vb_cnt !== 45) begin errors++; $display("FAIL vblank_lines: got %0d required 45", vb_cnt); end
        y = 0;
    endtask

    task automatic test_deferred();
        logic [11:0] r;
        newframe = 1;
        #1;
        vectors++;
        if (pal_wr_ready !== 1'b1) begin errors++; $display("FAIL clean_frame_ready: got %b required 1", pal_wr_ready); end
        step();
        newframe = 0; exp_fc++;
        pix(20, 0, r);
        vectors++;
        if (r !== 12'h555) begin errors++; $display("FAIL idx5_before: got %h required 555", r); end
        pal_write(4'd5, 12'hF00);
        pix(20, 0, r);
        vectors++;
        if (r !== 12'h555) begin errors++; $display("FAIL idx5_same_frame: got %h required 555", r); end
        pix(21, 100, r);
        vectors++;
        if (r !== 12'h555) begin errors++; $display("FAIL idx5_lower_row: got %h required 555", r); end
        nf();
        pix(20, 0, r);
        vectors++;
        if (r !== 12'hF00) begin errors++; $display("FAIL idx5_next_frame: got %h required F00", r); end
        vectors++;
        if (frame_cnt !== exp_fc) begin errors++; $display("FAIL frame_cnt: got %h required %h", frame_cnt, exp_fc); end
    endtask

    task automatic test_collision();
        logic [11:0] r;
        pal_write(4'd7, 12'h00F);
        newframe = 1; pal_wr_valid = 1; pal_wr_idx = 4'd2; pal_wr_rgb = 12'h0F0;
        #1;
        vectors++;
        if (pal_wr_ready !== 1'b0) begin errors++; $display("FAIL commit_ready: got %b required 0", pal_wr_ready); end
        step();
        newframe = 0; exp_fc++;
        #1;
        vectors++;
        if (pal_wr_ready !== 1'b1) begin errors++; $display("FAIL after_commit_ready: got %b required 1", pal_wr_ready); end
        step();
        pal_wr_valid = 0;
        pix(28, 0, r);
        vectors++;
        if (r !== 12'h00F) begin errors++; $display("FAIL idx7_committed: got %h required 00F", r); end
        pix(8, 0, r);
        vectors++;
        if (r !== 12'h222) begin errors++; $display("FAIL idx2_deferred: got %h required 222", r); end
        nf();
        pix(9, 4, r);
        vectors++;
        if (r !== 12'h0F0) begin errors++; $display("FAIL idx2_frame_after_next: got %h required 0F0", r); end
    endtask

    task automatic test_wrap_reset();
        logic [11:0] r;
        int n = 16'hFFFF - int'(exp_fc);
        newframe = 1;
        step(n);
        newframe = 0;
        exp_fc = exp_fc + 16'(n);
        vectors++;
        if (frame_cnt !== 16'hFFFF) begin errors++; $display("FAIL cnt_max: got %h required FFFF", frame_cnt); end
        nf();
        vectors++;
        if (frame_cnt !== 16'h0000) begin errors++; $display("FAIL cnt_wrap: got %h required 0000", frame_cnt); end
        nf();
        x = 12; y = 9; valid = 1; hsync = 0;
        step(L);
        vectors++;
        if (rgb !== 12'h333 || frame_cnt !== 16'h0001 || hsync_o !== 1'b0) begin
            errors++; $display("FAIL pre_reset: got rgb=%h cnt=%h hs=%b required 333 0001 0", rgb, frame_cnt, hsync_o);
        end
        #2;
        rst_n = 0;
        #1;
        vectors++;
        if ({rgb, hsync_o, vsync_o, vblank} !== {12'h000, 3'b110} || frame_cnt !== 16'h0 || ram_addr !== 15'h0 || pal_wr_ready !== 1'b0) begin
            errors++; $display("FAIL async_reset: got rgb=%h hs=%b vs=%b vb=%b cnt=%h addr=%h rdy=%b required 000 1 1 0 0000 0000 0",
                               rgb, hsync_o, vsync_o, vblank, frame_cnt, ram_addr, pal_wr_ready);
        end
        valid = 0; hsync = 1;
        step(2);
        rst_n = 1;
        step(3);
        pix(20, 0, r);
        vectors++;
        if (r !== 12'h555) begin errors++; $display("FAIL palette_after_reset: got %h required 555", r); end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_frame();
        test_deferred();
        test_collision();
        test_wrap_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
